controle: RTL

- Control unit (FSM) that sequences the 16-bit datapath `operativo` to evaluate a polynomial in X using Horner's form.
- Quadratic mode: Resultado = (A*X + B)*X + C. Linear mode: Resultado = B*X + C.
- Drives every datapath control input (lx, m0, m1, m2, h, ls, lh, done). Owns the start/done handshake toward the system level.
- Sits beside `operativo` in the top level; both share ck and rst.

---
 rtl/controle_pkg.sv | 10 +
 rtl/controle_if.sv | 16 +
 rtl/controle.sv | 83 ++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// controle_pkg: state encoding, mux select codes and ULA opcodes shared by the
// Horner control unit and its datapath.
package controle_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, MUL1, ADD_B, MUL_S, ADD_C, FIN} state_t;
    localparam logic [1:0] M0_ZERO  = 2'd0, M0_A = 2'd1, M0_B = 2'd2, M0_C = 2'd3;
    localparam logic [1:0] M1_OUTM0 = 2'd0, M1_X = 2'd1, M1_S = 2'd2, M1_H = 2'd3;
    localparam logic [1:0] M2_X     = 2'd0, M2_OUTM0 = 2'd1, M2_S = 2'd2, M2_H = 2'd3;
    localparam logic H_ADD = 1'b0;
    localparam logic H_MUL = 1'b1;
endpackage

// File: rtl/controle_if.sv
// controle_if: start/done handshake plus every datapath control line.
interface controle_if;
    logic       start;
    logic       mode;
    logic       busy;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
    modport master (input start, mode, output busy, lx, m0, m1, m2, h, ls, lh, done);
    modport slave  (output start, mode, input busy, lx, m0, m1, m2, h, ls, lh, done);
endinterface

// File: rtl/controle.sv
// controle: Moore FSM sequencing the datapath through Horner evaluation,
// quadratic (A*X+B)*X+C or linear B*X+C, selected by the mode latched with start.
module controle
    import controle_pkg::*;
(
    input logic ck,
    input logic rst,
    controle_if.master bus
);
    state_t state, nxt;
    logic   mode_q;
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) mode_q <= bus.mode;
        end
    end
    // Unused encodings fall into default: all outputs low, back to IDLE.
    always_comb begin
        nxt      = IDLE;
        bus.busy = 1'b1;
        bus.lx   = 1'b0;
        bus.m0   = M0_ZERO;
        bus.m1   = M1_OUTM0;
        bus.m2   = M2_X;
        bus.h    = H_ADD;
        bus.ls   = 1'b0;
        bus.lh   = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                nxt      = bus.start ? LOAD : IDLE;
            end
            LOAD: begin
                bus.lx = 1'b1;
                nxt    = MUL1;
            end
            MUL1: begin
                bus.m0 = mode_q ? M0_B : M0_A;
                bus.m1 = M1_OUTM0;
                bus.m2 = M2_X;
                bus.h  = H_MUL;
                bus.lh = 1'b1;
                nxt    = mode_q ? ADD_C : ADD_B;
            end
            ADD_B: begin
                bus.m0 = M0_B;
                bus.m1 = M1_H;
                bus.m2 = M2_OUTM0;
                bus.ls = 1'b1;
                nxt    = MUL_S;
            end
            MUL_S: begin
                bus.m1 = M1_S;
                bus.m2 = M2_X;
                bus.h  = H_MUL;
                bus.lh = 1'b1;
                nxt    = ADD_C;
            end
            ADD_C: begin
                bus.m0 = M0_C;
                bus.m1 = M1_H;
                bus.m2 = M2_OUTM0;
                bus.ls = 1'b1;
                nxt    = FIN;
            end
            FIN: begin
                bus.m1   = M1_S;
                bus.m2   = M2_OUTM0;
                bus.done = 1'b1;
                nxt      = IDLE;
            end
            default: begin
                bus.busy = 1'b0;
                nxt      = IDLE;
            end
        endcase
    end
endmodule
